// File: rtl/kd_run_sequencer.sv
// Command scheduler for KD_top: queues NTT/INTT requests and runs each one as an
// active phase followed by its Done phase. Optional watchdog: KD_SEQ_TIMEOUT_EN.
module kd_run_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int IDLE_GAP    = 2,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic       cmd_kd,
    output logic [3:0] run_mode,
    output logic       kd_mode,
    input  logic [1:0] done_flag,
    output logic       busy,
    output logic       rsp_valid,
    output logic [3:0] rsp_op,
    output logic [1:0] rsp_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GW = $clog2(IDLE_GAP + 1) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, RUN, DONE, REPORT, GAP} state_t;
    state_t state, state_nxt;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic [3:0]    head_op, cur_op, run_mode_nxt, rsp_op_nxt;
    logic          head_kd, rsp_set, timeout;
    logic [1:0]    rsp_err_nxt;
    logic [GW-1:0] gap_cnt;

    function automatic logic is_legal(input logic [3:0] op, input logic kd);
        case (op)
            4'd1, 4'd3, 4'd7, 4'd9: return !kd;
            4'd5, 4'd11:            return kd;
            default:                return 1'b0;
        endcase
    endfunction

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign busy      = (state != IDLE) || !empty;
    assign {head_kd, head_op} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_kd, cmd_op};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

`ifdef KD_SEQ_TIMEOUT_EN
    // Per-phase watchdog, restarted whenever RUN or DONE is entered.
    logic [14:0] tmo_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (state_nxt != state && (state_nxt == RUN || state_nxt == DONE))
            tmo_cnt <= '0;
        else if (state == RUN || state == DONE)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
    assign timeout = (tmo_cnt == 15'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        rsp_set     = 1'b0;
        rsp_err_nxt = 2'd0;
        rsp_op_nxt  = cur_op;
        case (state)
            IDLE: if (!empty) begin
                pop = 1'b1;
                if (is_legal(head_op, head_kd)) begin
                    state_nxt = SETUP;
                end else begin
                    rsp_set     = 1'b1;
                    rsp_err_nxt = 2'd1;
                    rsp_op_nxt  = head_op;
                end
            end
            SETUP: state_nxt = RUN;
            RUN: begin
                if (done_flag == 2'b01) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    state_nxt   = REPORT;
                    rsp_set     = 1'b1;
                    rsp_err_nxt = 2'd2;
                end
            end
            DONE: begin
                if (done_flag == 2'b10) begin
                    state_nxt = REPORT;
                    rsp_set   = 1'b1;
                end else if (timeout) begin
                    state_nxt   = REPORT;
                    rsp_set     = 1'b1;
                    rsp_err_nxt = 2'd2;
                end
            end
            REPORT:  state_nxt = (IDLE_GAP == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt >= GW'(IDLE_GAP)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // run_mode is registered from the next state so KD_top sees a clean code.
        case (state_nxt)
            RUN:     run_mode_nxt = cur_op;
            DONE:    run_mode_nxt = cur_op + 4'd1;
            default: run_mode_nxt = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_op    <= 4'd0;
            kd_mode   <= 1'b0;
            run_mode  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_op    <= 4'd0;
            rsp_err   <= 2'd0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            run_mode  <= run_mode_nxt;
            rsp_valid <= rsp_set;
            if (rsp_set) begin
                rsp_op  <= rsp_op_nxt;
                rsp_err <= rsp_err_nxt;
            end
            // kd_mode is valid throughout SETUP, one cycle ahead of the active code.
            if (pop && state_nxt == SETUP) begin
                cur_op  <= head_op;
                kd_mode <= head_kd;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : GW'(1);
        end
    end
endmodule

// File: tb/tb_kd_run_sequencer.sv
// Directed bench for kd_run_sequencer: records run_mode changes and responses as
// nibble/byte signatures and compares them with hand-derived sequences.
module tb_kd_run_sequencer;
    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_kd;
    logic [3:0] cmd_op;
    logic [1:0] done_flag;
    logic       cmd_ready, kd_mode, busy, rsp_valid;
    logic [3:0] run_mode, rsp_op;
    logic [1:0] rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kd_run_sequencer #(.FIFO_DEPTH(4), .IDLE_GAP(2), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_kd(cmd_kd), .run_mode(run_mode), .kd_mode(kd_mode),
        .done_flag(done_flag), .busy(busy), .rsp_valid(rsp_valid),
        .rsp_op(rsp_op), .rsp_err(rsp_err)
    );

    // run_mode changes as nibbles, responses as bytes {op, 2'b00, err}
    logic        clr = 1'b0;
    logic [3:0]  prev_rm = 4'd0;
    logic [63:0] rm_sig = '0, rsp_sig = '0;
    int          rm_n = 0, rsp_n = 0;

    always @(negedge clk) begin
        prev_rm <= run_mode;
        if (clr) begin
            rm_sig <= '0; rm_n <= 0; rsp_sig <= '0; rsp_n <= 0;
        end else begin
            if (run_mode !== prev_rm) begin
                rm_sig <= {rm_sig[59:0], run_mode};
                rm_n   <= rm_n + 1;
            end
            if (rsp_valid) begin
                rsp_sig <= {rsp_sig[55:0], rsp_op, 2'b00, rsp_err};
                rsp_n   <= rsp_n + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_rec();
        clr = 1'b1; tick(1); clr = 1'b0;
    endtask

    task automatic push(input logic [3:0] op, input logic kd);
        logic acc;
        acc = 1'b0;
        cmd_op = op; cmd_kd = kd; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        cmd_valid = 1'b0;
        if (!acc) begin total++; bad++; $display("FAIL push_accept op=%0d never accepted", op); end
    endtask

    task automatic wait_rm(input logic [3:0] v);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (run_mode === v) begin hit = 1'b1; break; end
            tick(1);
        end
        if (!hit) begin total++; bad++; $display("FAIL wait_run_mode got=%0d exp=%0d", run_mode, v); end
    endtask

    task automatic finish_run(input logic [3:0] op);
        wait_rm(op);
        done_flag = 2'b01; tick(1); done_flag = 2'b00;
        wait_rm(op + 4'd1);
        done_flag = 2'b10; tick(1); done_flag = 2'b00;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin idle = 1'b1; break; end
            tick(1);
        end
        if (!idle) begin total++; bad++; $display("FAIL wait_idle busy stuck high"); end
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_kd = 1'b0; done_flag = 2'b00;
        #3;
        total++; if (run_mode !== 4'd0) begin bad++; $display("FAIL rst_run_mode got=%0d exp=0", run_mode); end
        total++; if (kd_mode !== 1'b0) begin bad++; $display("FAIL rst_kd_mode got=%0b exp=0", kd_mode); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b exp=0", rsp_valid); end
        total++; if (rsp_op !== 4'd0 || rsp_err !== 2'd0) begin bad++; $display("FAIL rst_rsp got=%0d/%0d exp=0/0", rsp_op, rsp_err); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick(1);
    endtask

    task automatic test_single_kyber();
        clear_rec();
        push(4'd1, 1'b0);
        total++; if (run_mode !== 4'd0 || busy !== 1'b1) begin bad++; $display("FAIL kyber_pop_cycle run_mode=%0d busy=%0b exp=0/1", run_mode, busy); end
        tick(1);
        total++; if (run_mode !== 4'd0) begin bad++; $display("FAIL kyber_setup_cycle got=%0d exp=0", run_mode); end
        tick(1);
        total++; if (run_mode !== 4'd1) begin bad++; $display("FAIL kyber_latency got=%0d exp=1", run_mode); end
        tick(24);
        done_flag = 2'b10; tick(1); done_flag = 2'b11; tick(1); done_flag = 2'b00;
        total++; if (run_mode !== 4'd1) begin bad++; $display("FAIL kyber_run_ignore got=%0d exp=1", run_mode); end
        done_flag = 2'b01; tick(1); done_flag = 2'b00;
        tick(12);
        done_flag = 2'b01; tick(1); done_flag = 2'b11; tick(1); done_flag = 2'b00;
        total++; if (run_mode !== 4'd2) begin bad++; $display("FAIL kyber_done_ignore got=%0d exp=2", run_mode); end
        done_flag = 2'b10; tick(1); done_flag = 2'b00;
        wait_idle();
        total++; if (rm_sig[11:0] !== 12'h120 || rm_n !== 3) begin bad++; $display("FAIL kyber_run_seq got=%0h/%0d exp=120/3", rm_sig, rm_n); end
        total++; if (rsp_sig[7:0] !== 8'h10 || rsp_n !== 1) begin bad++; $display("FAIL kyber_rsp got=%0h/%0d exp=10/1", rsp_sig, rsp_n); end
    endtask

    task automatic test_chain();
        int gap;
        clear_rec();
        push(4'd3, 1'b0); push(4'd9, 1'b0); push(4'd7, 1'b0);
        finish_run(4'd3);
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (run_mode === 4'd9) break;
            gap++;
        end
        total++; if (gap !== 4) begin bad++; $display("FAIL chain_spacing got=%0d exp=4", gap); end
        finish_run(4'd9);
        finish_run(4'd7);
        wait_idle();
        total++; if (rm_sig[35:0] !== 36'h3409A0780 || rm_n !== 9) begin bad++; $display("FAIL chain_run_seq got=%0h/%0d exp=3409a0780/9", rm_sig, rm_n); end
        total++; if (rsp_sig[23:0] !== 24'h309070 || rsp_n !== 3) begin bad++; $display("FAIL chain_rsp got=%0h/%0d exp=309070/3", rsp_sig, rsp_n); end
    endtask

    task automatic test_dilithium();
        clear_rec();
        push(4'd5, 1'b1);
        tick(1);
        total++; if (kd_mode !== 1'b1 || run_mode !== 4'd0) begin bad++; $display("FAIL dil_kd_lead kd=%0b run_mode=%0d exp=1/0", kd_mode, run_mode); end
        tick(1);
        total++; if (run_mode !== 4'd5) begin bad++; $display("FAIL dil_active got=%0d exp=5", run_mode); end
        finish_run(4'd5);
        wait_idle();
        push(4'd11, 1'b1);
        finish_run(4'd11);
        wait_idle();
        total++; if (rm_sig[23:0] !== 24'h560BC0 || rm_n !== 6) begin bad++; $display("FAIL dil_run_seq got=%0h/%0d exp=560bc0/6", rm_sig, rm_n); end
        total++; if (rsp_sig[15:0] !== 16'h50B0 || rsp_n !== 2) begin bad++; $display("FAIL dil_rsp got=%0h/%0d exp=50b0/2", rsp_sig, rsp_n); end
    endtask

    task automatic test_illegal();
        clear_rec();
        push(4'd5, 1'b0);
        tick(1);
        total++; if (rsp_valid !== 1'b1 || rsp_op !== 4'd5 || rsp_err !== 2'd1) begin bad++; $display("FAIL illegal_rsp_timing got=%0b/%0d/%0d exp=1/5/1", rsp_valid, rsp_op, rsp_err); end
        push(4'd4, 1'b0);
        wait_idle();
        total++; if (rsp_sig[15:0] !== 16'h5141 || rsp_n !== 2) begin bad++; $display("FAIL illegal_rsp got=%0h/%0d exp=5141/2", rsp_sig, rsp_n); end
        total++; if (rm_n !== 0 || run_mode !== 4'd0) begin bad++; $display("FAIL illegal_run_mode changes=%0d run_mode=%0d exp=0/0", rm_n, run_mode); end
        total++; if (kd_mode !== 1'b1) begin bad++; $display("FAIL illegal_kd_mode got=%0b exp=1", kd_mode); end
    endtask

    task automatic test_backpressure();
        int n;
        clear_rec();
        push(4'd1, 1'b0);
        wait_rm(4'd1);
        push(4'd3, 1'b0); push(4'd7, 1'b0); push(4'd9, 1'b0); push(4'd1, 1'b0);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0b exp=0", cmd_ready); end
        cmd_op = 4'd3; cmd_kd = 1'b0; cmd_valid = 1'b1;
        tick(2);
        done_flag = 2'b01; tick(1); done_flag = 2'b00;
        done_flag = 2'b10; tick(1); done_flag = 2'b00;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            tick(1);
            n++;
        end
        total++; if (n !== 4) begin bad++; $display("FAIL bp_ready_rise got=%0d exp=4", n); end
        tick(1);
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_fifth_accepted got=%0b exp=0", cmd_ready); end
        finish_run(4'd3); finish_run(4'd7); finish_run(4'd9); finish_run(4'd1); finish_run(4'd3);
        wait_idle();
        total++; if (rsp_sig[47:0] !== 48'h103070901030 || rsp_n !== 6) begin bad++; $display("FAIL bp_rsp got=%0h/%0d exp=103070901030/6", rsp_sig, rsp_n); end
    endtask

`ifdef KD_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        clear_rec();
        push(4'd1, 1'b0);
        tick(25);
        wait_idle();
        total++; if (rsp_sig[7:0] !== 8'h12 || rsp_n !== 1) begin bad++; $display("FAIL timeout_rsp got=%0h/%0d exp=12/1", rsp_sig, rsp_n); end
    endtask
`endif

    task automatic test_reset_mid_run();
        clear_rec();
        push(4'd7, 1'b0);
        wait_rm(4'd7);
        #2 rst = 1'b0;
        #1;
        total++; if (run_mode !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_async run_mode=%0d busy=%0b exp=0/0", run_mode, busy); end
        tick(2);
        rst = 1'b1;
        tick(4);
        total++; if (rsp_n !== 0) begin bad++; $display("FAIL midrst_no_rsp got=%0d exp=0", rsp_n); end
        push(4'd9, 1'b0);
        finish_run(4'd9);
        wait_idle();
        total++; if (rsp_sig[7:0] !== 8'h90 || rsp_n !== 1) begin bad++; $display("FAIL midrst_recover got=%0h/%0d exp=90/1", rsp_sig, rsp_n); end
    endtask

    initial begin
        test_reset();
        test_single_kyber();
        test_chain();
        test_dilithium();
        test_illegal();
        test_backpressure();
`ifdef KD_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
